// File: rtl/accel_spi_pkg.sv
// ============================================================================
// Module  : accel_spi_pkg
// Brief   : Register map, command-byte fields and FSM encoding for the
//           accelerometer SPI responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package accel_spi_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_MB_BIT   = 6;
    localparam int CMD_ADDR_MSB = 5;
    localparam int CMD_ADDR_LSB = 0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CMD  = 2'd1;
    localparam state_t ST_RD   = 2'd2;
    localparam state_t ST_WR   = 2'd3;

    function automatic logic is_data_addr(input logic [5:0] addr);
        return (addr >= ADDR_DATAX0) && (addr <= ADDR_DATAZ1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_pin_sync.sv
// ============================================================================
// Module  : spi_pin_sync
// Brief   : Synchronises SCLK/MOSI/CS_N into sys_clk and flags SCLK edges.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic spi_sclk,
    input  logic spi_cs,
    input  logic spi_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_active,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   sclk_s;

    // SCLK and CS_N reset to their idle-high levels so no phantom edge appears.
    generate
        if (SYNC_STAGES > 1) begin : g_multi_stage
            always_ff @(posedge sys_clk) begin
                if (reset) begin
                    sclk_sync_q <= '1;
                    cs_sync_q   <= '1;
                    mosi_sync_q <= '0;
                end else begin
                    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
                    cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
                    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
                end
            end
        end else begin : g_single_stage
            always_ff @(posedge sys_clk) begin
                if (reset) begin
                    sclk_sync_q <= '1;
                    cs_sync_q   <= '1;
                    mosi_sync_q <= '0;
                end else begin
                    sclk_sync_q <= spi_sclk;
                    cs_sync_q   <= spi_cs;
                    mosi_sync_q <= spi_mosi;
                end
            end
        end
    endgenerate

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sclk_prev_q <= 1'b1;
        end else begin
            sclk_prev_q <= sclk_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_active = ~cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/accel_spi_responder.sv
// ============================================================================
// Module  : accel_spi_responder
// Brief   : SPI mode-3 slave emulating an ADXL345-style accelerometer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_spi_responder
    import accel_spi_pkg::*;
#(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        spi_sclk,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic [15:0] x_sample,
    input  logic [15:0] y_sample,
    input  logic [15:0] z_sample,
    input  logic        sample_valid,
    output logic        data_ready,
    output logic        measure_en,
    output logic [7:0]  data_format,
    output logic [7:0]  bw_rate
);

    logic sclk_rise;
    logic sclk_fall;
    logic cs_active;
    logic mosi_s;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .spi_sclk  (spi_sclk),
        .spi_cs    (spi_cs),
        .spi_mosi  (spi_mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_active (cs_active),
        .mosi_s    (mosi_s)
    );

    state_t      state_q,       state_d;
    logic [2:0]  bit_cnt_q,     bit_cnt_d;
    logic [6:0]  shreg_q,       shreg_d;
    logic [6:0]  tx_q,          tx_d;
    logic [5:0]  addr_q,        addr_d;
    logic        mb_q,          mb_d;
    logic        shadow_use_q,  shadow_use_d;
    logic        data_rd_q,     data_rd_d;
    logic        miso_q,        miso_d;
    logic        oe_q,          oe_d;
    logic [7:0]  bw_rate_q,     bw_rate_d;
    logic [5:0]  power_ctl_q,   power_ctl_d;
    logic [7:0]  data_format_q, data_format_d;
    logic [47:0] hold_q,        hold_d;
    logic [47:0] shadow_q,      shadow_d;
    logic        data_ready_q,  data_ready_d;
    logic        overrun_q,     overrun_d;

    logic [7:0]  rx_byte;
    logic [7:0]  rd_byte;
    logic [47:0] data_src;
    logic        frame_clear;

    assign rx_byte  = {shreg_q, mosi_s};
    assign data_src = shadow_use_q ? shadow_q : hold_q;

    // Byte layout of hold/shadow: [7:0]=X0 ... [47:40]=Z1, matching 0x32..0x37.
    always_comb begin
        rd_byte = 8'h00;
        case (addr_q)
            ADDR_DEVID:       rd_byte = DEVID;
            ADDR_BW_RATE:     rd_byte = bw_rate_q;
            ADDR_POWER_CTL:   rd_byte = {2'b00, power_ctl_q};
            ADDR_INT_SOURCE:  rd_byte = {data_ready_q, 6'b000000, overrun_q};
            ADDR_DATA_FORMAT: rd_byte = data_format_q;
            ADDR_DATAX0:      rd_byte = data_src[7:0];
            ADDR_DATAX1:      rd_byte = data_src[15:8];
            ADDR_DATAY0:      rd_byte = data_src[23:16];
            ADDR_DATAY1:      rd_byte = data_src[31:24];
            ADDR_DATAZ0:      rd_byte = data_src[39:32];
            ADDR_DATAZ1:      rd_byte = data_src[47:40];
            default:          rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        tx_d          = tx_q;
        addr_d        = addr_q;
        mb_d          = mb_q;
        shadow_use_d  = shadow_use_q;
        data_rd_d     = data_rd_q;
        miso_d        = miso_q;
        oe_d          = oe_q;
        bw_rate_d     = bw_rate_q;
        power_ctl_d   = power_ctl_q;
        data_format_d = data_format_q;
        hold_d        = hold_q;
        shadow_d      = shadow_q;
        data_ready_d  = data_ready_q;
        overrun_d     = overrun_q;
        frame_clear   = 1'b0;

        if (!cs_active) begin
            // Any in-flight partial byte is simply dropped here.
            frame_clear  = (state_q != ST_IDLE) && data_rd_q;
            state_d      = ST_IDLE;
            bit_cnt_d    = 3'd0;
            oe_d         = 1'b0;
            miso_d       = 1'b0;
            data_rd_d    = 1'b0;
            shadow_use_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_CMD;
                    bit_cnt_d = 3'd0;
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shreg_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
                            mb_d   = rx_byte[CMD_MB_BIT];
                            if (rx_byte[CMD_RW_BIT]) begin
                                state_d = ST_RD;
                                if (is_data_addr(rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB])) begin
                                    shadow_d     = hold_q;
                                    shadow_use_d = 1'b1;
                                end
                            end else begin
                                state_d = ST_WR;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (sclk_fall) begin
                        oe_d = 1'b1;
                        if (bit_cnt_q == 3'd0) begin
                            miso_d = rd_byte[7];
                            tx_d   = rd_byte[6:0];
                        end else begin
                            miso_d = tx_q[6];
                            tx_d   = {tx_q[5:0], 1'b0};
                        end
                    end
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (is_data_addr(addr_q)) begin
                                data_rd_d = 1'b1;
                            end
                            if (mb_q) begin
                                addr_d = addr_q + 6'd1;
                            end
                        end
                    end
                end
                ST_WR: begin
                    if (sclk_rise) begin
                        shreg_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            case (addr_q)
                                ADDR_BW_RATE:     bw_rate_d     = rx_byte;
                                ADDR_POWER_CTL:   power_ctl_d   = rx_byte[5:0];
                                ADDR_DATA_FORMAT: data_format_d = rx_byte;
                                default:          ;
                            endcase
                            if (mb_q) begin
                                addr_d = addr_q + 6'd1;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A new sample beats a simultaneous end-of-read clear.
        if (sample_valid && power_ctl_q[3]) begin
            hold_d       = {z_sample, y_sample, x_sample};
            data_ready_d = 1'b1;
            overrun_d    = frame_clear ? 1'b0 : (overrun_q | data_ready_q);
        end else if (frame_clear) begin
            data_ready_d = 1'b0;
            overrun_d    = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shreg_q       <= 7'd0;
            tx_q          <= 7'd0;
            addr_q        <= 6'd0;
            mb_q          <= 1'b0;
            shadow_use_q  <= 1'b0;
            data_rd_q     <= 1'b0;
            miso_q        <= 1'b0;
            oe_q          <= 1'b0;
            bw_rate_q     <= BW_RATE_RST;
            power_ctl_q   <= 6'd0;
            data_format_q <= 8'h00;
            hold_q        <= 48'd0;
            shadow_q      <= 48'd0;
            data_ready_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            tx_q          <= tx_d;
            addr_q        <= addr_d;
            mb_q          <= mb_d;
            shadow_use_q  <= shadow_use_d;
            data_rd_q     <= data_rd_d;
            miso_q        <= miso_d;
            oe_q          <= oe_d;
            bw_rate_q     <= bw_rate_d;
            power_ctl_q   <= power_ctl_d;
            data_format_q <= data_format_d;
            hold_q        <= hold_d;
            shadow_q      <= shadow_d;
            data_ready_q  <= data_ready_d;
            overrun_q     <= overrun_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign data_ready  = data_ready_q;
    assign measure_en  = power_ctl_q[3];
    assign data_format = data_format_q;
    assign bw_rate     = bw_rate_q;

endmodule

`default_nettype wire
